// File: rtl/sio_edge_sync.sv
// Synchronizer plus edge detector for a single-bit input.
// STAGES flops bring the input into the clk domain (STAGES = 0 bypasses
// them for signals that are already synchronous, such as a divider bit),
// and a one-flop history turns the synchronized level into rise/fall pulses.
module sio_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic w_level;
    logic r_prev;

    generate
        if (STAGES == 0) begin : g_bypass
            assign w_level = i_d;
        end else begin : g_sync
            logic [STAGES-1:0] r_sync;

            // Shift the raw input through the synchronizer chain; idles high like a serial clock line
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync <= '1;
                end else begin
                    r_sync <= (r_sync << 1) | STAGES'(i_d);
                end
            end

            assign w_level = r_sync[STAGES-1];
        end
    endgenerate

    // Remember the previous synchronized level so transitions become one-clk pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_rise = w_level & ~r_prev;
    assign o_fall = ~w_level & r_prev;

endmodule

// File: rtl/lr35902_sio.sv
// Game Boy (LR35902) serial port: SB data register at FF01, SC control at FF02.
// One byte is shifted MSB first: sout changes on serial-clock falls, sin is
// captured on rises. The serial clock is either a divider bit (internal mode,
// also driven on sclk_out) or the synchronized external sclk_in.
module lr35902_sio #(
    parameter int DIV_BIT     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        adr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] div,
    output logic        irq,
    input  logic        sclk_in,
    output logic        sclk_out,
    input  logic        sin,
    output logic        sout
);

    localparam logic ADR_SB = 1'b1;
    localparam logic ADR_SC = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } sio_state_t;

    sio_state_t r_state;
    logic [7:0] r_sb;
    logic       r_active;
    logic       r_intClk;
    logic [2:0] r_count;
    logic       r_sclkOut;
    logic       r_sout;
    logic       r_irq;
    logic [SYNC_STAGES-1:0] r_sinSync;

    logic w_divRise;
    logic w_divFall;
    logic w_extRise;
    logic w_extFall;
    logic w_rise;
    logic w_fall;
    logic w_sinSync;
    logic w_unused;

    // Reads have no side effects and only a few divider bits matter
    assign w_unused = ^{read, div};

    sio_edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_extSync (
        .clk    (clk),
        .reset  (reset),
        .i_d    (sclk_in),
        .o_rise (w_extRise),
        .o_fall (w_extFall)
    );

    sio_edge_sync #(
        .STAGES (0)
    ) u_divSync (
        .clk    (clk),
        .reset  (reset),
        .i_d    (div[DIV_BIT]),
        .o_rise (w_divRise),
        .o_fall (w_divFall)
    );

    // Serial data in goes through the same depth as sclk_in so both stay aligned at a rise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sinSync <= '1;
        end else begin
            r_sinSync <= (r_sinSync << 1) | SYNC_STAGES'(sin);
        end
    end

    assign w_sinSync = r_sinSync[SYNC_STAGES-1];
    assign w_rise    = r_intClk ? w_divRise : w_extRise;
    assign w_fall    = r_intClk ? w_divFall : w_extFall;

    // Transfer FSM: an SC write takes priority over any serial edge in the same cycle;
    // the 8th rise lands in HIGH with active cleared, and HIGH falls back to IDLE next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_sb      <= 8'h00;
            r_active  <= 1'b0;
            r_intClk  <= 1'b0;
            r_count   <= 3'd0;
            r_sclkOut <= 1'b1;
            r_sout    <= 1'b1;
            r_irq     <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (write && adr == ADR_SC) begin
                r_intClk  <= din[0];
                r_active  <= din[7];
                r_count   <= 3'd0;
                r_state   <= ST_IDLE;
                r_sclkOut <= 1'b1;
            end else begin
                if (write && adr == ADR_SB && !r_active) begin
                    r_sb <= din;
                end
                if (!r_active) begin
                    r_state   <= ST_IDLE;
                    r_sclkOut <= 1'b1;
                end else begin
                    case (r_state)
                        ST_IDLE, ST_HIGH: begin
                            if (w_fall) begin
                                r_state   <= ST_LOW;
                                r_sout    <= r_sb[7];
                                r_sclkOut <= ~r_intClk;
                            end
                        end
                        ST_LOW: begin
                            if (w_rise) begin
                                r_state   <= ST_HIGH;
                                r_sb      <= {r_sb[6:0], w_sinSync};
                                r_count   <= r_count + 3'd1;
                                r_sclkOut <= 1'b1;
                                if (r_count == 3'd7) begin
                                    r_active <= 1'b0;
                                    r_irq    <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign dout     = (adr == ADR_SB) ? r_sb : {r_active, 6'b111111, r_intClk};
    assign irq      = r_irq;
    assign sclk_out = r_sclkOut;
    assign sout     = r_sout;

endmodule

// File: doc/lr35902_sio.md
LR35902_SIO -- requirements
Module: lr35902_sio

Interface
REQ-001 Parameter DIV_BIT, default 8, is the index of the div bit used as the internal serial clock (8192 Hz at a 4.194 MHz clk).
REQ-002 Parameter SYNC_STAGES, default 2, is the number of flops in the external-clock synchronizer.
REQ-003 clk  input  1  system clock; one clock domain, all state on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 adr  input  1  register select: 1 = SB (FF01), 0 = SC (FF02).
REQ-006 din  input  8  CPU write data.
REQ-007 dout  output  8  read data for the selected register, combinational on adr.
REQ-008 read  input  1  read strobe; no side effects.
REQ-009 write  input  1  write strobe, already qualified by chip select.
REQ-010 div  input  16  free-running divider from the timer block.
REQ-011 irq  output  1  serial interrupt request, one-clk pulse.
REQ-012 sclk_in  input  1  external serial clock (asynchronous).
REQ-013 sclk_out  output  1  serial clock driven when in internal mode.
REQ-014 sin  input  1  serial data in (asynchronous).
REQ-015 sout  output  1  serial data out.

Function
REQ-016 SB read returns the shift register; SC read returns {active, 6'b111111, int_clk}.
REQ-017 SB write loads the shift register only when idle; while a transfer is active it is ignored.
REQ-018 SC write sets int_clk = din[0] and active = din[7].
- When din[7] = 1, the bit counter clears to 0 and the transfer restarts.
- When din[7] = 0, an active transfer aborts: counter cleared, sclk_out = 1, SB keeps its partly shifted value, no irq.
REQ-019 States: IDLE, LOW, HIGH.
- IDLE -> LOW on a serial-clock falling edge while active.
- LOW -> HIGH on the next rising edge.
- HIGH -> LOW on the next falling edge, or HIGH -> IDLE after the 8th rising edge.
REQ-020 Internal clock: edges come from div[DIV_BIT] transitions; sclk_out follows the phase (0 in LOW, 1 in HIGH and IDLE).
REQ-021 External clock: edges come from sclk_in after the SYNC_STAGES synchronizer plus an edge detector; sclk_out stays 1.
REQ-022 Falling edge: sout <= SB[7].
REQ-023 Rising edge: SB <= {SB[6:0], sin_sync} and the counter increments (3-bit, 0..7, wrap).
REQ-024 8th rising edge: active clears and irq = 1 for exactly one clk, in the same cycle SB takes its final value.
REQ-025 In IDLE, edges are ignored and sout holds its last value.
REQ-026 If an SC write and a serial edge occur in the same cycle, the write wins and the edge is discarded.
REQ-027 If an SB write and a rising edge occur in the same cycle while active, the shift wins.
REQ-028 sin is sampled through the same synchronizer depth as sclk_in.

Reset
REQ-029 Reset values: SB = 0x00, active = 0, int_clk = 0, counter = 0, state IDLE, sclk_out = 1, sout = 1, irq = 0, synchronizer flops = 1.
REQ-030 Reset asserted mid-transfer aborts the transfer without asserting irq.

Structure
REQ-031 No shared package; register offsets and the state encoding are local parameters.
REQ-032 One sub-module, sio_edge_sync, provides the synchronizer plus rise/fall pulse outputs; it is instantiated for sclk_in and reused for the div bit with 0 sync stages.

Verification
REQ-033 Reset -> dout: SB 0x00, SC 0x7E; sclk_out = 1, sout = 1, irq = 0.
REQ-034 Internal transfer: SB = 0xA5, SC = 0x81, sin tied 1.
- sout shows 1,0,1,0,0,1,0,1 on successive sclk_out falls.
- After 8 rises (~8×512 clk): SB = 0xFF, SC = 0x7F, one irq pulse.
REQ-035 External transfer: SB = 0x3C, SC = 0x80, drive 8 sclk_in cycles (period 40 clk) with sin pattern 0x96.
- SB = 0x96 and irq pulses once.
- sclk_out stays 1 throughout.
REQ-036 Abort: start an internal transfer, then after 3 rises write SC = 0x01.
- SC reads 0x7F and sclk_out = 1.
- No irq within 10000 clk.
REQ-037 SB write during an active transfer (write 0x00 after 2 rises, sin = 1, initial SB = 0x00) -> final SB = 0xFF (write ignored).
REQ-038 Reset pulsed at bit 5 of an external transfer -> all outputs return to REQ-029 values the next cycle; no irq.
